// File: rtl/adc_sampler_quant.sv
// ADC emulation stage: decimates the shaped waveform, rescales and clamps it to an
// unsigned code, and hands samples over through a 2-entry show-ahead FIFO.
module adc_sampler_quant #(
   parameter int BITS_IN  = 50,
   parameter int BITS_OUT = 12,
   parameter int SHIFT    = 24,
   parameter int PEDESTAL = 50,
   parameter int DECIM    = 4,
   parameter int CNT_W    = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                enable,
   input  logic [BITS_IN-1:0]  in,
   output logic [BITS_OUT-1:0] out_data,
   output logic                out_sat_hi,
   output logic                out_sat_lo,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [CNT_W-1:0]    sat_count,
   output logic [CNT_W-1:0]    drop_count
);

   localparam int PH_W = $clog2(DECIM);
   localparam logic [PH_W-1:0]         PH_LAST  = PH_W'(DECIM - 1);
   localparam logic signed [BITS_IN:0] PED_EXT  = (BITS_IN + 1)'(PEDESTAL);
   localparam logic signed [BITS_IN:0] CODE_MAX = (BITS_IN + 1)'(2**BITS_OUT - 1);

   typedef struct packed {
      logic [BITS_OUT-1:0] code;
      logic                hi;
      logic                lo;
   } samp_t;

   logic [PH_W-1:0]         phase_q, phase_d;
   logic                    capture;
   logic signed [BITS_IN:0] v1_q, v1_d;
   logic                    v1_vld_q, s2_vld_q;
   samp_t                   s2_q, s2_d;
   samp_t                   head_q, head_d, tail_q;
   logic                    tail_we;
   logic [1:0]              cnt_q, cnt_d;
   logic                    push, pop, drop;
   logic [CNT_W-1:0]        sat_q, drop_q;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      capture = enable && (phase_q == '0);
      phase_d = phase_q;
      if (enable) phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);

      // Sign-extend before shifting so the pedestal add cannot overflow.
      v1_d = ($signed({in[BITS_IN-1], in}) >>> SHIFT) + PED_EXT;

      s2_d.lo   = v1_q[BITS_IN];
      s2_d.hi   = !v1_q[BITS_IN] && (v1_q > CODE_MAX);
      s2_d.code = s2_d.lo ? '0 : s2_d.hi ? '1 : v1_q[BITS_OUT-1:0];
   end

   assign push = s2_vld_q;
   assign pop  = out_valid && out_ready;

   always_comb begin
      head_d  = head_q;
      tail_we = 1'b0;
      cnt_d   = cnt_q;
      drop    = 1'b0;
      case (cnt_q)
         2'd0: if (push) begin
            head_d = s2_q;
            cnt_d  = 2'd1;
         end
         2'd1: begin
            if (push && pop) head_d = s2_q;
            else if (push) begin
               tail_we = 1'b1;
               cnt_d   = 2'd2;
            end else if (pop) cnt_d = 2'd0;
         end
         default: begin
            if (pop) begin
               head_d  = tail_q;
               tail_we = push;
               cnt_d   = push ? 2'd2 : 2'd1;
            end else if (push) drop = 1'b1;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         phase_q  <= '0;
         v1_vld_q <= 1'b0;
         s2_vld_q <= 1'b0;
         cnt_q    <= 2'd0;
         head_q   <= '0;
         sat_q    <= '0;
         drop_q   <= '0;
      end else begin
         phase_q  <= phase_d;
         v1_vld_q <= capture;
         s2_vld_q <= v1_vld_q;
         cnt_q    <= cnt_d;
         head_q   <= head_d;
         if (v1_vld_q && (s2_d.hi || s2_d.lo) && (sat_q != '1)) sat_q <= sat_q + CNT_W'(1);
         if (drop && (drop_q != '1)) drop_q <= drop_q + CNT_W'(1);
      end
   end

   // NOTE: datapath and tail storage have no reset; they are only observed behind a valid or count.
   always_ff @(posedge clock) begin
      if (capture)  v1_q   <= v1_d;
      if (v1_vld_q) s2_q   <= s2_d;
      if (tail_we)  tail_q <= s2_q;
   end

   assign out_valid  = (cnt_q != 2'd0);
   assign out_data   = head_q.code;
   assign out_sat_hi = head_q.hi;
   assign out_sat_lo = head_q.lo;
   assign sat_count  = sat_q;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_adc_sampler_quant.sv
// Self-checking bench for adc_sampler_quant: a queue-based sample model is compared
// against the DUT every cycle, with literal expectations pinning the model.
module tb_adc_sampler_quant;

   localparam int BITS_IN  = 50;
   localparam int BITS_OUT = 12;
   localparam int SHIFT    = 24;
   localparam int PEDESTAL = 50;
   localparam int DECIM    = 4;
   localparam int CNT_W    = 16;
   localparam longint SCALE   = 64'sd1 <<< SHIFT;
   localparam longint MAXC    = (64'sd1 <<< BITS_OUT) - 1;
   localparam longint CNT_MAX = (64'sd1 <<< CNT_W) - 1;

   logic                clock = 1'b0;
   logic                reset, enable, out_ready;
   logic [BITS_IN-1:0]  in_s;
   logic [BITS_OUT-1:0] out_data;
   logic                out_sat_hi, out_sat_lo, out_valid;
   logic [CNT_W-1:0]    sat_count, drop_count;

   int checks = 0;
   int errors = 0;

   adc_sampler_quant #(
      .BITS_IN(BITS_IN), .BITS_OUT(BITS_OUT), .SHIFT(SHIFT),
      .PEDESTAL(PEDESTAL), .DECIM(DECIM), .CNT_W(CNT_W)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable), .in(in_s),
      .out_data(out_data), .out_sat_hi(out_sat_hi), .out_sat_lo(out_sat_lo),
      .out_valid(out_valid), .out_ready(out_ready),
      .sat_count(sat_count), .drop_count(drop_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d", name, act, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      longint code;
      bit     hi;
      bit     lo;
      longint n;
   } ent_t;

   function automatic ent_t quantise(input longint x, input longint n);
      ent_t   e;
      longint q, v;
      q = x / SCALE;
      if (x < 0 && q * SCALE != x) q = q - 1;   // floor toward -inf
      v = q + PEDESTAL;
      e.n    = n;
      e.lo   = (v < 0);
      e.hi   = (v > MAXC);
      e.code = e.lo ? 0 : (e.hi ? MAXC : v);
      return e;
   endfunction

   ent_t   pipe[$];
   ent_t   fq[$];
   ent_t   last;
   int     phase;
   longint cyc = 0;
   longint m_sat, m_drop;
   bit     model_ok = 0;

   always @(posedge clock) begin
      if (reset) begin
         pipe.delete();
         fq.delete();
         phase    = 0;
         m_sat    = 0;
         m_drop   = 0;
         last     = '{0, 0, 0, 0};
         model_ok = 1;
      end else begin
         if (fq.size() > 0 && out_ready) void'(fq.pop_front());
         foreach (pipe[i])
            if (pipe[i].n + 1 == cyc && (pipe[i].hi || pipe[i].lo) && m_sat < CNT_MAX) m_sat++;
         if (pipe.size() > 0 && pipe[0].n + 2 == cyc) begin
            ent_t e;
            e = pipe.pop_front();
            if (fq.size() < 2) fq.push_back(e);
            else if (m_drop < CNT_MAX) m_drop++;
         end
         if (enable && phase == 0) pipe.push_back(quantise(longint'($signed(in_s)), cyc));
         if (enable) phase = (phase + 1) % DECIM;
         if (fq.size() > 0) last = fq[0];
      end
      cyc++;
   end

   always @(negedge clock) begin
      if (model_ok) begin
         check("valid",      64'(out_valid),  64'(fq.size() > 0));
         check("data",       64'(out_data),   64'(last.code));
         check("sat_hi",     64'(out_sat_hi), 64'(last.hi));
         check("sat_lo",     64'(out_sat_lo), 64'(last.lo));
         check("sat_count",  64'(sat_count),  64'(m_sat));
         check("drop_count", 64'(drop_count), 64'(m_drop));
      end
   end

   // ---------------- stimulus ----------------
   task automatic cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   function automatic logic [BITS_IN-1:0] scaled(input longint v);
      longint t;
      t = v * SCALE;
      return t[BITS_IN-1:0];
   endfunction

   initial begin
      ent_t   pin;
      longint d0, lv;
      int     guard;

      pin = quantise(-1, 0);
      check("model_floor_neg1", 64'(pin.code), 64'd49);
      pin = quantise(-(100 * SCALE), 0);
      check("model_clip_lo", 64'(pin.lo), 64'd1);

      reset = 1'b1; enable = 1'b0; out_ready = 1'b1; in_s = '0;
      cycles(3);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_data",  64'(out_data),  64'd0);
      check("rst_sat",   64'(sat_count), 64'd0);
      check("rst_drop",  64'(drop_count), 64'd0);

      // 1: constant 100<<24, first valid two edges after the first capture
      reset = 1'b0; enable = 1'b1; in_s = scaled(100);
      cycles(1); check("t1_valid_n0", 64'(out_valid), 64'd0);
      cycles(1); check("t1_valid_n1", 64'(out_valid), 64'd0);
      cycles(1); check("t1_valid_n2", 64'(out_valid), 64'd1);
                 check("t1_data",     64'(out_data),  64'd150);
      cycles(20);

      // 2: -1 floors to -1, code 49
      in_s = '1;
      cycles(12);
      check("t2_data",  64'(out_data),  64'd49);
      check("t2_hi",    64'(out_sat_hi), 64'd0);
      check("t2_lo",    64'(out_sat_lo), 64'd0);
      check("t2_satc",  64'(sat_count),  64'd0);

      // 3: clipping low and high
      in_s = scaled(-100);
      cycles(12);
      check("t3_lo_data", 64'(out_data),   64'd0);
      check("t3_lo_flag", 64'(out_sat_lo), 64'd1);
      in_s = scaled(5000);
      cycles(12);
      check("t3_hi_data", 64'(out_data),   64'd4095);
      check("t3_hi_flag", 64'(out_sat_hi), 64'd1);

      // 4: consumer stalls for 5 captures starting from an empty FIFO
      in_s = scaled(10);
      cycles(12);
      guard = 0;
      while (out_valid && guard < 10) begin
         cycles(1);
         guard++;
      end
      check("t4_empty_wait", 64'(out_valid), 64'd0);
      d0 = longint'(drop_count);
      out_ready = 1'b0;
      cycles(20);
      check("t4_held_valid", 64'(out_valid), 64'd1);
      check("t4_held_data",  64'(out_data),  64'd60);
      check("t4_drops",      64'(longint'(drop_count) - d0), 64'd3);
      out_ready = 1'b1;
      cycles(6);

      // 5: enable gap mid-run
      in_s = scaled(300);
      cycles(3);
      enable = 1'b0;
      cycles(7);
      enable = 1'b1;
      cycles(12);
      check("t5_data", 64'(out_data), 64'd350);

      // randomized operation
      for (int i = 0; i < 600; i++) begin
         lv = (longint'($urandom_range(0, 5400)) - 300) * SCALE + longint'($urandom_range(0, 16777215));
         in_s      = lv[BITS_IN-1:0];
         enable    = ($urandom_range(0, 9) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         reset     = ($urandom_range(0, 199) == 0);
         cycles(1);
      end
      reset = 1'b0;

      // 6: reset while full with the pipeline loaded
      enable = 1'b1; out_ready = 1'b0; in_s = scaled(-20);
      cycles(17);
      reset = 1'b1;
      cycles(1);
      reset = 1'b0;
      check("t6_valid", 64'(out_valid),  64'd0);
      check("t6_sat",   64'(sat_count),  64'd0);
      check("t6_drop",  64'(drop_count), 64'd0);
      out_ready = 1'b1; in_s = scaled(7);
      cycles(3);
      check("t6_first_valid", 64'(out_valid), 64'd1);
      check("t6_first_data",  64'(out_data),  64'd57);
      cycles(10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
